// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined RV32 core.
// Owns the PC and presents it combinationally to instruction memory. The word that
// memory returns is captured into IF/ID together with its PC and a valid flag.
// A start-gated RUN/IDLE FSM decides whether the stage fetches at all.
// Inside RUN, a load-use stall takes priority over a taken-branch redirect,
// and a redirect takes priority over a normal sequential fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic             running_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_reg,      state_next;
    logic [31:0]       pc_reg,         pc_next;
    logic [31:0]       ifid_pc_reg,    ifid_pc_next;
    logic [31:0]       ifid_instr_reg, ifid_instr_next;
    logic              ifid_valid_reg, ifid_valid_next;
    logic              misalign_reg,   misalign_next;
    logic [CNT_W-1:0]  count_reg,      count_next;

    // Next-state and datapath selection.
    // Every register holds by default; each branch overrides only what it changes.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        misalign_next   = misalign_reg;
        count_next      = count_reg;

        case (state_reg)
            IDLE: begin
                // The start edge only arms the FSM; the first fetch happens on the next edge.
                ifid_pc_next    = 32'h0000_0000;
                ifid_instr_next = NOP_INSTR;
                ifid_valid_next = 1'b0;
                if (start_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!start_i) begin
                    // Dropping start behaves like an idle edge: the PC holds and a bubble is inserted.
                    state_next      = IDLE;
                    ifid_pc_next    = 32'h0000_0000;
                    ifid_instr_next = NOP_INSTR;
                    ifid_valid_next = 1'b0;
                end else if (stall_i) begin
                    // Freeze everything. ID re-asserts any branch once the stall clears.
                    state_next = RUN;
                end else if (branch_i) begin
                    // Force the target to word alignment, and record the misaligned request stickily.
                    pc_next         = {branch_target_i[31:2], 2'b00};
                    ifid_pc_next    = 32'h0000_0000;
                    ifid_instr_next = NOP_INSTR;
                    ifid_valid_next = 1'b0;
                    if (branch_target_i[1:0] != 2'b00) begin
                        misalign_next = 1'b1;
                    end
                end else begin
                    ifid_pc_next    = pc_reg;
                    ifid_instr_next = imem_instr_i;
                    ifid_valid_next = 1'b1;
                    pc_next         = pc_reg + 32'd4;
                    count_next      = count_reg + CNT_ONE;
                end
            end
            default: begin
                state_next      = IDLE;
                ifid_pc_next    = 32'h0000_0000;
                ifid_instr_next = NOP_INSTR;
                ifid_valid_next = 1'b0;
            end
        endcase
    end

    // State register. The active-low synchronous reset overrides every other input.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            ifid_pc_reg    <= 32'h0000_0000;
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            misalign_reg   <= misalign_next;
            count_reg      <= count_next;
        end
    end

    assign imem_addr_o   = pc_reg;
    assign ifid_pc_o     = ifid_pc_reg;
    assign ifid_instr_o  = ifid_instr_reg;
    assign ifid_valid_o  = ifid_valid_reg;
    assign running_o     = (state_reg == RUN);
    assign misalign_o    = misalign_reg;
    assign instr_count_o = count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage.
// A table of per-edge vectors gives the inputs and the expected outputs.
// A scoreboard queue additionally tracks each fetched {pc, instr} pair from the edge
// that issues it to the edge where it appears in IF/ID.
// Instruction memory is modelled as addr ^ KEY.
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        running;
    logic        misalign;
    logic [31:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        stall;
        logic        branch;
        logic [31:0] target;
        logic        fetch;      // this edge should capture a fresh instruction
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_count;
        logic        exp_run;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    vec_t   vecs[$];
    fetch_t sb[$];

    if_stage dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (target),
        .imem_addr_o     (imem_addr),
        .imem_instr_i    (imem_instr),
        .ifid_pc_o       (ifid_pc),
        .ifid_instr_o    (ifid_instr),
        .ifid_valid_o    (ifid_valid),
        .running_o       (running),
        .misalign_o      (misalign),
        .instr_count_o   (count)
    );

    assign imem_instr = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic st, input logic b,
                       input logic [31:0] t, input logic f, input logic [31:0] a,
                       input logic v, input logic [31:0] p, input logic [31:0] ins,
                       input logic [31:0] c, input logic run, input logic mis);
        vec_t x;
        x.rst_n = r; x.start = s; x.stall = st; x.branch = b; x.target = t;
        x.fetch = f; x.exp_addr = a; x.exp_valid = v; x.exp_pc = p;
        x.exp_instr = ins; x.exp_count = c; x.exp_run = run; x.exp_mis = mis;
        vecs.push_back(x);
    endtask

    task automatic chk32(input int idx, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s actual=%h required=%h", idx, name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] prev_addr;
        fetch_t      f;

        rst_n = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0;

        //   rst st stl br target        fetch addr         v  ifid_pc       ifid_instr     cnt run mis
        add(0, 1, 0, 1, 32'h0000_0040, 0, 32'h0000_0000, 0, 32'h0000_0000, NOP,           0, 0, 0); // reset wins
        add(1, 1, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0000, NOP,           0, 1, 0); // IDLE->RUN, no fetch
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 32'hA5A5_0000, 1, 1, 0);
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004, 32'hA5A5_0004, 2, 1, 0);
        add(1, 1, 1, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0004, 32'hA5A5_0004, 2, 1, 0); // stall
        add(1, 1, 1, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0004, 32'hA5A5_0004, 2, 1, 0); // stall
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0008, 32'hA5A5_0008, 3, 1, 0); // resume at 8
        add(1, 1, 0, 1, 32'h0000_0040, 0, 32'h0000_0040, 0, 32'h0000_0000, NOP,           3, 1, 0); // branch bubble
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0044, 1, 32'h0000_0040, 32'hA5A5_0040, 4, 1, 0);
        add(1, 1, 1, 1, 32'h0000_0080, 0, 32'h0000_0044, 1, 32'h0000_0040, 32'hA5A5_0040, 4, 1, 0); // stall beats branch
        add(1, 1, 0, 1, 32'h0000_0042, 0, 32'h0000_0040, 0, 32'h0000_0000, NOP,           4, 1, 1); // misaligned target
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0044, 1, 32'h0000_0040, 32'hA5A5_0040, 5, 1, 1);
        add(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0000_0000, NOP,           5, 1, 1);
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 6, 1, 1); // PC wraps
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 32'hA5A5_0000, 7, 1, 1);
        add(1, 0, 0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0000_0000, NOP,           7, 0, 1); // RUN->IDLE
        add(1, 0, 0, 1, 32'h0000_0100, 0, 32'h0000_0004, 0, 32'h0000_0000, NOP,           7, 0, 1); // idle ignores branch
        add(1, 1, 0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0000_0000, NOP,           7, 1, 1); // re-arm
        add(1, 1, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004, 32'hA5A5_0004, 8, 1, 1);
        add(0, 1, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0000, NOP,           0, 0, 0); // reset mid-run
        add(1, 1, 1, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0000, NOP,           0, 1, 0); // stall ignored in IDLE
        add(1, 1, 1, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0000, NOP,           0, 1, 0); // stalled in RUN
        add(1, 0, 1, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0000, NOP,           0, 0, 0); // drop start

        prev_addr = 32'h0;
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n  = vecs[i].rst_n;
            start  = vecs[i].start;
            stall  = vecs[i].stall;
            branch = vecs[i].branch;
            target = vecs[i].target;
            if (vecs[i].fetch) begin
                f.pc    = prev_addr;
                f.instr = prev_addr ^ KEY;
                sb.push_back(f);
            end
            @(posedge clk);
            #1;
            chk32(i, "imem_addr",  imem_addr,          vecs[i].exp_addr);
            chk32(i, "ifid_valid", {31'b0, ifid_valid}, {31'b0, vecs[i].exp_valid});
            chk32(i, "ifid_pc",    ifid_pc,            vecs[i].exp_pc);
            chk32(i, "ifid_instr", ifid_instr,         vecs[i].exp_instr);
            chk32(i, "count",      count,              vecs[i].exp_count);
            chk32(i, "running",    {31'b0, running},   {31'b0, vecs[i].exp_run});
            chk32(i, "misalign",   {31'b0, misalign},  {31'b0, vecs[i].exp_mis});
            if (vecs[i].fetch) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL vec%0d scoreboard_empty actual=0 required=1", i);
                end else begin
                    f = sb.pop_front();
                    chk32(i, "sb_pc",    ifid_pc,    f.pc);
                    chk32(i, "sb_instr", ifid_instr, f.instr);
                end
            end
            $display("vec %0d: rst=%0b start=%0b stall=%0b br=%0b tgt=%h -> addr=%h ifid=%h/%h/%0b cnt=%0d run=%0b mis=%0b",
                     i, rst_n, start, stall, branch, target, imem_addr, ifid_pc, ifid_instr,
                     ifid_valid, count, running, misalign);
            prev_addr = vecs[i].exp_addr;
        end

        chk32(-1, "sb_leftover", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
